// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S sck/ws timing generator.
// Holds the controller state type, the bit-index width and the RES legality check.
// Imported by i2s_sck_ws_gen and i2s_half_period_cnt.
package i2s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int BIT_IDX_W = 5;

  // Bits per channel must fit a BIT_IDX_W index and leave at least an MSB and an LSB.
  function automatic bit res_legal(input int res);
    return (res >= 2) && (res <= 32);
  endfunction

endpackage

// File: rtl/i2s_half_period_cnt.sv
// Half-period counter: counts clk cycles up to the latched divider, flags terminal count.
// Latency: tc is a compare of registered state (no input-to-output path); load/clear take effect next edge.
// Backpressure: none; advances whenever en is high.
// Ports: clk, rst_n; clr zeroes the count; en advances it; load captures div into div_q;
//        tc is high while the count equals div_q.
module i2s_half_period_cnt
  import i2s_pkg::*;
#(
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 en,
  input  logic                 load,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 tc
);

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div_q;

  assign tc = (cnt == div_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

  // Loads coincide with a count wrap, so the new half-period always starts from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
    end else if (load) begin
      div_q <= div;
    end
  end

endmodule

// File: rtl/i2s_sck_ws_gen.sv
// I2S master timing generator: divides clk into sck/ws and emits sck edge and frame-start strobes.
// Latency: all outputs registered; enable seen in cycle N gives busy/frame_start in cycle N+1.
// Backpressure: none; free-running while enable is high, dropping enable abandons the word.
// Ports: clk, rst_n (async, active low), enable, div (half-period minus 1) in;
//        sck, ws, sck_rise, sck_fall, frame_start, bit_idx, busy out.
module i2s_sck_ws_gen
  import i2s_pkg::*;
#(
  parameter int DIV_WIDTH = 8,
  parameter int RES       = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] div,
  output logic                 sck,
  output logic                 ws,
  output logic                 sck_rise,
  output logic                 sck_fall,
  output logic                 frame_start,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 busy
);

  if (!res_legal(RES)) begin : g_res_check
    $error("i2s_sck_ws_gen: RES must be in 2..32");
  end

  localparam logic [BIT_IDX_W-1:0] MSB_IDX = BIT_IDX_W'(RES - 1);

  state_t               state, state_d;
  logic                 sck_d, ws_d, rise_d, fall_d, fs_d;
  logic [BIT_IDX_W-1:0] bit_idx_d;
  logic                 cnt_clr, cnt_en, div_load, tc;

  i2s_half_period_cnt #(
    .DIV_WIDTH(DIV_WIDTH)
  ) u_half_period_cnt (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .load (div_load),
    .div  (div),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sck         <= 1'b0;
      ws          <= 1'b0;
      sck_rise    <= 1'b0;
      sck_fall    <= 1'b0;
      frame_start <= 1'b0;
      bit_idx     <= MSB_IDX;
    end else begin
      state       <= state_d;
      sck         <= sck_d;
      ws          <= ws_d;
      sck_rise    <= rise_d;
      sck_fall    <= fall_d;
      frame_start <= fs_d;
      bit_idx     <= bit_idx_d;
    end
  end

  always_comb begin
    state_d   = state;
    sck_d     = sck;
    ws_d      = ws;
    bit_idx_d = bit_idx;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    fs_d      = 1'b0;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    div_load  = 1'b0;

    case (state)
      IDLE: begin
        cnt_clr   = 1'b1;
        sck_d     = 1'b0;
        ws_d      = 1'b0;
        bit_idx_d = MSB_IDX;
        if (enable) begin
          state_d  = RUN;
          fs_d     = 1'b1;
          div_load = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d   = IDLE;
          sck_d     = 1'b0;
          ws_d      = 1'b0;
          bit_idx_d = MSB_IDX;
          cnt_clr   = 1'b1;
        end else begin
          cnt_en = 1'b1;
          if (tc) begin
            sck_d = ~sck;
            if (!sck) begin
              rise_d = 1'b1;
            end else begin
              fall_d = 1'b1;
              if (bit_idx == '0) begin
                bit_idx_d = MSB_IDX;
                // ws already flipped back to left at the previous LSB fall, so a low ws
                // here marks the end of the right word: new frame, new divider.
                if (!ws) begin
                  fs_d     = 1'b1;
                  div_load = 1'b1;
                end
              end else begin
                bit_idx_d = bit_idx - 1'b1;
                // ws leads the next word's MSB by one sck period.
                if (bit_idx == BIT_IDX_W'(1)) begin
                  ws_d = ~ws;
                end
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state == RUN);

endmodule
